// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NREAD_DEF = 2;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sweep controller: walks registers 1..NREGS-1 zeroing one per cycle.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CLEAR;
      cnt   <= AW'(1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Register 0 is hardwired, so the sweep starts at 1 and ends at NREGS-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(NREGS - 1)) state_nxt = READY;
      end
      READY: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = AW'(1);
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_en   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with x0 hardwiring, write-through
// bypass, sweep-based clear and a registered debug read port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = NREAD_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic [NREAD*$clog2(NREGS)-1:0] ra,
  output logic [NREAD*XLEN-1:0]   rd,
  input  logic [1:0]              we,
  input  logic [2*$clog2(NREGS)-1:0] wa,
  input  logic [2*XLEN-1:0]       wd,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [XLEN-1:0]         dbg_data
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] mem [NREGS];
  logic            clr_en;
  logic [AW-1:0]   clr_addr;
  logic [AW-1:0]   wa0;
  logic [AW-1:0]   wa1;
  logic [XLEN-1:0] wd0;
  logic [XLEN-1:0] wd1;
  logic [1:0]      wv;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_val;

  regfile_clear_fsm #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );

  assign wa0 = wa[0 +: AW];
  assign wa1 = wa[AW +: AW];
  assign wd0 = wd[0 +: XLEN];
  assign wd1 = wd[XLEN +: XLEN];

  assign wv[0] = we[0] && (wa0 != '0) && !busy;
  assign wv[1] = we[1] && (wa1 != '0) && !busy;

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wv[0]) mem[wa0] <= wd0;
      if (wv[1]) mem[wa1] <= wd1;
    end
  end

  always_comb begin
    rd      = '0;
    rd_addr = '0;
    rd_val  = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_addr = ra[i*AW +: AW];
      rd_val  = mem[rd_addr];
      if (wv[0] && (wa0 == rd_addr)) rd_val = wd0;
      if (wv[1] && (wa1 == rd_addr)) rd_val = wd1;
      if (busy || (rd_addr == '0)) rd_val = '0;
      rd[i*XLEN +: XLEN] = rd_val;
    end
  end

  // Debug capture holds zero while the sweep runs so unswept contents never leak.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dbg_data <= '0;
    end else if (busy || (dbg_addr == '0)) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= mem[dbg_addr];
    end
  end

endmodule
